// File: rtl/alu_sequencer_if.sv
// Instruction source -> sequencer handshake: in_instr is accepted on a posedge where in_valid && in_ready.
// The source holds in_instr steady while in_valid is high; in_ready depends only on sequencer state, never on in_valid.
interface alu_sequencer_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Queued 16-bit instruction issuer for the regfile + ALU pair: READ / EXEC / RETIRE per instruction.
// Optional feature macro ALU_SEQ_TRAP_EN: an illegal opcode halts the sequencer until reset.
module alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    in_if,
  output logic [15:0]       dp_instr,
  output logic              dp_we,
  output logic              done,
  output logic              illegal,
  output logic              halted,
  output logic              busy,
  output logic [ADDR_W:0]   q_count,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_RETIRE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  state_t              state_q;
  logic [15:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic [15:0]         dp_instr_q;
  logic                dp_we_q, done_q, illegal_q;
  logic                push_w, pop_w, not_empty, trap_now;
  logic [15:0]         head;

  function automatic logic is_illegal(input logic [3:0] op);
    return op >= 4'd11;
  endfunction

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign push_w    = in_if.in_valid && in_if.in_ready;

`ifdef ALU_SEQ_TRAP_EN
  logic halted_q;
  assign trap_now = illegal_q;
  assign halted   = halted_q;
`else
  assign trap_now = 1'b0;
  assign halted   = 1'b0;
`endif

  // The head is consumed only from IDLE or from a RETIRE that is not trapping.
  assign pop_w = not_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_RETIRE) && !trap_now));

  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w)      count_d = count_q + CNT_ONE;
    else if (pop_w && !push_w) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= in_if.in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dp_instr_q <= '0;
      dp_we_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      dp_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop_w) begin
            dp_instr_q <= head;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          // Write enable covers the whole EXEC cycle so the regfile can write at its negedge.
          dp_we_q <= !is_illegal(dp_instr_q[15:12]);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          done_q    <= 1'b1;
          illegal_q <= is_illegal(dp_instr_q[15:12]);
          state_q   <= S_RETIRE;
        end
        S_RETIRE: begin
`ifdef ALU_SEQ_TRAP_EN
          if (illegal_q) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else
`endif
          if (pop_w) begin
            dp_instr_q <= head;
            state_q    <= S_READ;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_if.in_ready = (count_q != CNT_FULL);
  assign dp_instr       = dp_instr_q;
  assign dp_we          = dp_we_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign busy           = (state_q != S_IDLE) || not_empty;
  assign q_count        = count_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small regfile/ALU harness (op 9 = add immediate, others a+b).
// Build with ALU_SEQ_TRAP_EN defined to exercise the halting variant of the illegal-opcode test.
module tb_alu_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if in_if ();
  logic [15:0] dp_instr;
  logic        dp_we, done, illegal, halted, busy;
  logic [2:0]  q_count;
  logic [2:0]  dbg_state;

  alu_sequencer #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .in_if(in_if),
    .dp_instr(dp_instr), .dp_we(dp_we), .done(done), .illegal(illegal),
    .halted(halted), .busy(busy), .q_count(q_count), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------- regfile + ALU harness ----------------
  logic [15:0] rf [16];
  logic [15:0] rd_a, rd_b;
  logic        rf_init = 1'b1;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [3:0] imm);
    if (op == 4'd9) return a + {12'd0, imm};
    return a + b;
  endfunction

  always @(posedge clk) begin
    rd_a <= rf[dp_instr[7:4]];
    rd_b <= rf[dp_instr[3:0]];
  end

  always @(negedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
      rf[3] <= 16'd5;
      rf[7] <= 16'd1;
    end else if (dp_we) begin
      rf[dp_instr[11:8]] <= alu(dp_instr[15:12], rd_a, rd_b, dp_instr[3:0]);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int cyc = 0;
  int done_cnt = 0, illegal_cnt = 0, adj_err = 0, we_run = 0;
  int last_done_cyc = 0, done_gap = 0;
  logic prev_we = 1'b0;
  logic [15:0] sb_e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      we_run  = 0;
      prev_we = 1'b0;
    end else begin
      if (dp_we && prev_we) adj_err++;
      prev_we = dp_we;
      if (dp_we) we_run++;
      if (done) begin
        done_cnt++;
        if (illegal) illegal_cnt++;
        done_gap      = cyc - last_done_cyc;
        last_done_cyc = cyc;
        check("sb_avail", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          check("retire_instr", dp_instr, sb_e);
          check("retire_illegal", illegal, sb_e[15:12] >= 4'd11);
          check("retire_we_cycles", we_run, (sb_e[15:12] >= 4'd11) ? 0 : 1);
        end
        we_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_init = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_instr = 16'd0;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    rf_init = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    in_if.in_valid = 1'b1;
    in_if.in_instr = w;
    step();
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      step();
      k++;
    end
    check("done_count", done_cnt, n);
  endtask

  // ---------------- directed tests ----------------
  logic [15:0] fill_w [7] = '{16'h1A00, 16'h2B00, 16'h3C00, 16'h4D00, 16'h5E00, 16'h6F00, 16'h7100};
  int base, ill_base;

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_instr = 16'd0;

    // 1: reset then idle
    do_reset();
    check("rst_in_ready", in_if.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dp_we", dp_we, 0);
    check("rst_q_count", q_count, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_halted", halted, 0);
    check("rst_dp_instr", dp_instr, 16'h0000);
    check("rst_state", dbg_state, 3'd0);

    // 2: single add r3 = r7 + r3
    exp_q.push_back(16'h0373);
    push(16'h0373);
    check("t2_qcount_after_push", q_count, 1);
    check("t2_dp_instr_hold", dp_instr, 16'h0000);
    step();
    check("t2_dp_instr_pop", dp_instr, 16'h0373);
    check("t2_we_read", dp_we, 0);
    check("t2_qcount_after_pop", q_count, 0);
    step();
    check("t2_we_exec", dp_we, 1);
    check("t2_done_exec", done, 0);
    step();
    check("t2_we_retire", dp_we, 0);
    check("t2_done_retire", done, 1);
    step();
    check("t2_done_clear", done, 0);
    check("t2_busy_idle", busy, 0);
    check("t2_dp_instr_idle", dp_instr, 16'h0373);
    check("t2_r3", rf[3], 16'd6);

    // 3: dependent pair r3 = r7 + r3 ; r5 = r3 + 3
    do_reset();
    base = done_cnt;
    exp_q.push_back(16'h0373);
    exp_q.push_back(16'h9533);
    push(16'h0373);
    push(16'h9533);
    wait_done(base + 2, 20);
    check("t3_done_gap", done_gap, 3);
    check("t3_r3", rf[3], 16'd6);
    check("t3_r5", rf[5], 16'd9);
    check("t3_we_adjacent", adj_err, 0);

    // 4: fill the queue while the FSM is busy; the seventh word meets in_ready=0
    do_reset();
    base = done_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back(fill_w[i]);
    for (int i = 0; i < 6; i++) push(fill_w[i]);
    check("t4_qcount_full", q_count, 4);
    check("t4_ready_full", in_if.in_ready, 0);
    push(fill_w[6]);
    check("t4_qcount_drop", q_count, 4);
    check("t4_ready_still_full", in_if.in_ready, 0);
    wait_done(base + 6, 40);
    for (int i = 0; i < 6; i++) step();
    check("t4_no_extra_done", done_cnt, base + 6);
    check("t4_sb_drained", exp_q.size(), 0);
    check("t4_qcount_empty", q_count, 0);

    // 5: illegal opcode followed by a legal add
    do_reset();
    base = done_cnt;
    ill_base = illegal_cnt;
`ifdef ALU_SEQ_TRAP_EN
    exp_q.push_back(16'hB123);
    push(16'hB123);
    push(16'h0373);
    wait_done(base + 1, 20);
    step();
    check("t5_halted", halted, 1);
    for (int i = 0; i < 12; i++) step();
    check("t5_no_issue", done_cnt, base + 1);
    check("t5_q_pending", q_count, 1);
    check("t5_busy_halt", busy, 1);
    check("t5_r3_unchanged", rf[3], 16'd5);
    check("t5_r1_unchanged", rf[1], 16'd0);
    push(16'h1100);
    push(16'h1200);
    push(16'h1300);
    check("t5_halt_fill", q_count, 4);
    check("t5_halt_ready", in_if.in_ready, 0);
`else
    exp_q.push_back(16'hB123);
    exp_q.push_back(16'h0373);
    push(16'hB123);
    push(16'h0373);
    wait_done(base + 2, 20);
    check("t5_illegal_count", illegal_cnt - ill_base, 1);
    check("t5_r1_unchanged", rf[1], 16'd0);
    check("t5_r3", rf[3], 16'd6);
    check("t5_halted", halted, 0);
`endif

    // 6: reset asserted during EXEC
    do_reset();
    base = done_cnt;
    push(16'h0373);
    push(16'h0444);
    check("t6_read_instr", dp_instr, 16'h0373);
    @(posedge clk);
    #1;
    check("t6_we_exec", dp_we, 1);
    check("t6_qcount_before", q_count, 1);
    rst = 1'b1;
    #1;
    check("t6_we_drop", dp_we, 0);
    check("t6_qcount_flush", q_count, 0);
    check("t6_busy", busy, 0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t6_no_done", done_cnt, base);
    check("t6_r3_unwritten", rf[3], 16'd5);
    check("t6_r4_unwritten", rf[4], 16'd0);

    check("we_adjacent_total", adj_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
